// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 control blocks (encrypt and decrypt).
// Holds the FSM state encoding, round/phase geometry and a few helpers.
package aes_pkg;

  // Control FSM states. The 2-bit encoding is fully used, but the FSM
  // still falls back to IDLE on any unexpected value.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_KEY_FWD = 2'd1,
    ST_ROUND   = 2'd2,
    ST_DONE    = 2'd3
  } aes_state_e;

  // Round geometry for AES-128.
  localparam int NR             = 10;
  localparam int ROUND_CYCLES   = 3;
  localparam int KEY_FWD_CYCLES = 10;
  localparam int KEY_IDX_W      = 4;
  localparam int PHASE_W        = 2;

  // Pre-sized counter bounds so comparisons need no width casts at use sites.
  localparam logic [KEY_IDX_W-1:0] KEY_FWD_FIRST = KEY_IDX_W'(1);
  localparam logic [KEY_IDX_W-1:0] KEY_FWD_LAST  = KEY_IDX_W'(KEY_FWD_CYCLES);
  localparam logic [KEY_IDX_W-1:0] ROUND_FIRST   = KEY_IDX_W'(NR - 1);
  localparam logic [KEY_IDX_W-1:0] ROUND_LAST    = KEY_IDX_W'(0);
  localparam logic [PHASE_W-1:0]   PHASE_FIRST   = PHASE_W'(0);
  localparam logic [PHASE_W-1:0]   PHASE_LAST    = PHASE_W'(ROUND_CYCLES - 1);

  // A block is in flight while the key is being expanded or rounds run.
  function automatic logic state_is_busy(aes_state_e s);
    return (s == ST_KEY_FWD) || (s == ST_ROUND);
  endfunction

  // The key schedule advances every forward-expansion cycle and on the
  // last phase of each inverse round.
  function automatic logic key_step_for(aes_state_e s, logic [PHASE_W-1:0] ph);
    return (s == ST_KEY_FWD) || ((s == ST_ROUND) && (ph == PHASE_LAST));
  endfunction

endpackage

// File: rtl/aes_ctrl_collision_irq.sv
// Flags a request that arrives while the engine is busy. The pulse appears
// one cycle after the offending request, once per offending cycle, so a
// request held high through a busy window yields a pulse train.
module aes_ctrl_collision_irq (
  input  logic clk,
  input  logic kill_n,
  input  logic in_en_i,
  input  logic busy_i,
  output logic irq_pulse_o
);

  logic irq_q;

  // Register the collision condition; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= in_en_i & busy_i;
    end
  end

  assign irq_pulse_o = irq_q;

endmodule

// File: rtl/aes_128_inv_control.sv
// Control sequencer for an iterative AES-128 decryptor. It expands the key
// forward to round 10, then walks the inverse rounds 9..0 at three cycles
// per round, steering the key schedule backwards and enabling
// InvMixColumns on every round but the last. No datapath lives here.
//
// Handshake: in_en is a request; start (= in_en & ~busy, gated by reset)
// is the accept. A request while busy is dropped and reported through
// in_en_collision_irq_pulse on the next cycle. out_en is a one-cycle
// plaintext-valid strobe in DONE; a request in DONE is accepted and the
// next block starts immediately.
module aes_128_inv_control
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 kill_n,
  input  logic                 in_en,
  output logic                 start,
  output logic                 busy,
  output logic                 key_step,
  output logic                 key_dir,
  output logic [KEY_IDX_W-1:0] key_round,
  output logic                 en_invmixcol,
  output logic                 out_en,
  output logic                 in_en_collision_irq_pulse,
  output logic [1:0]           dbg_state_o
);

  aes_state_e           state_q, state_d;
  logic [KEY_IDX_W-1:0] key_round_q, key_round_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;

  logic busy_q;
  logic key_step_q;
  logic key_dir_q;
  logic en_invmixcol_q;
  logic out_en_q;

  // Accept strobe: combinational so a DONE-cycle request chains directly.
  assign start = in_en & ~busy_q & kill_n;

  // Next-state and counter update for the round sequencer.
  always_comb begin
    state_d     = state_q;
    key_round_d = key_round_q;
    phase_d     = phase_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = PHASE_FIRST;
        if (start) begin
          state_d     = ST_KEY_FWD;
          key_round_d = KEY_FWD_FIRST;
        end else begin
          key_round_d = '0;
        end
      end
      ST_KEY_FWD: begin
        phase_d = PHASE_FIRST;
        if (key_round_q >= KEY_FWD_LAST) begin
          state_d     = ST_ROUND;
          key_round_d = ROUND_FIRST;
        end else begin
          key_round_d = key_round_q + 1'b1;
        end
      end
      ST_ROUND: begin
        if (phase_q >= PHASE_LAST) begin
          phase_d = PHASE_FIRST;
          if (key_round_q == ROUND_LAST) begin
            state_d     = ST_DONE;
            key_round_d = '0;
          end else begin
            key_round_d = key_round_q - 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        phase_d = PHASE_FIRST;
        if (start) begin
          state_d     = ST_KEY_FWD;
          key_round_d = KEY_FWD_FIRST;
        end else begin
          state_d     = ST_IDLE;
          key_round_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        key_round_d = '0;
        phase_d     = PHASE_FIRST;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state_q        <= ST_IDLE;
      key_round_q    <= '0;
      phase_q        <= PHASE_FIRST;
      busy_q         <= 1'b0;
      key_step_q     <= 1'b0;
      key_dir_q      <= 1'b0;
      en_invmixcol_q <= 1'b0;
      out_en_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_round_q    <= key_round_d;
      phase_q        <= phase_d;
      busy_q         <= state_is_busy(state_d);
      key_step_q     <= key_step_for(state_d, phase_d);
      key_dir_q      <= (state_d == ST_ROUND) && (phase_d == PHASE_LAST);
      en_invmixcol_q <= (state_d == ST_ROUND) && (phase_d == PHASE_LAST) &&
                        (key_round_d != ROUND_LAST);
      out_en_q       <= (state_d == ST_DONE);
    end
  end

  aes_ctrl_collision_irq u_collision_irq (
    .clk         (clk),
    .kill_n      (kill_n),
    .in_en_i     (in_en),
    .busy_i      (busy_q),
    .irq_pulse_o (in_en_collision_irq_pulse)
  );

  assign busy         = busy_q;
  assign key_step     = key_step_q;
  assign key_dir      = key_dir_q;
  assign key_round    = key_round_q;
  assign en_invmixcol = en_invmixcol_q;
  assign out_en       = out_en_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_aes_128_inv_control.sv
// Directed bench for the AES-128 decrypt control sequencer. Scenarios push
// the cycles at which each event must appear; a negedge monitor pops and
// compares whenever the DUT raises that event.
module tb_aes_128_inv_control;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       kill_n = 1'b0;
  logic       in_en = 1'b0;
  logic       start, busy, key_step, key_dir, en_invmixcol, out_en, irq;
  logic [3:0] key_round;
  logic [1:0] dbg_state;

  aes_128_inv_control dut (
    .clk                       (clk),
    .kill_n                    (kill_n),
    .in_en                     (in_en),
    .start                     (start),
    .busy                      (busy),
    .key_step                  (key_step),
    .key_dir                   (key_dir),
    .key_round                 (key_round),
    .en_invmixcol              (en_invmixcol),
    .out_en                    (out_en),
    .in_en_collision_irq_pulse (irq),
    .dbg_state_o               (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int base = 0;

  typedef struct packed {
    logic [31:0] c;
    logic        dir;
    logic [3:0]  rnd;
  } step_t;

  logic [31:0] exp_start_q[$];
  logic [31:0] exp_out_q[$];
  logic [31:0] exp_irq_q[$];
  step_t       exp_step_q[$];
  step_t       exp_imc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=asserted required=none (cycle %0d)", name, cyc - base);
  endtask

  // Move to the start of scenario cycle c (1 time unit after its rising edge).
  task automatic at(input int c);
    while (cyc < base + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_in(input int c);
    at(c);
    in_en = 1'b1;
    at(c + 1);
    in_en = 1'b0;
  endtask

  task automatic busy_at(input int c, input logic exp);
    at(c);
    @(negedge clk);
    check("busy", 32'(busy), 32'(exp));
  endtask

  // Expected events for a block accepted at scenario cycle t; events at or
  // after scenario cycle cut are not expected (block abandoned by reset).
  task automatic expect_block(input int t, input int cut);
    exp_start_q.push_back(32'(base + t));
    for (int k = 1; k <= 10; k++)
      if (t + k < cut) exp_step_q.push_back('{c: 32'(base + t + k), dir: 1'b0, rnd: 4'(k)});
    for (int k = 0; k < 10; k++) begin
      int c;
      c = t + 13 + 3 * k;
      if (c < cut) begin
        exp_step_q.push_back('{c: 32'(base + c), dir: 1'b1, rnd: 4'(9 - k)});
        if (k < 9) exp_imc_q.push_back('{c: 32'(base + c), dir: 1'b0, rnd: 4'(9 - k)});
      end
    end
    if (t + 41 < cut) exp_out_q.push_back(32'(base + t + 41));
  endtask

  task automatic expect_irq(input int c);
    exp_irq_q.push_back(32'(base + c));
  endtask

  // Apply reset, checking every output is quiet while it is held, even
  // with a request present.
  task automatic do_reset();
    kill_n = 1'b0;
    in_en  = 1'b1;
    @(negedge clk);
    check("rst_start", 32'(start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_key_step", 32'(key_step), 0);
    check("rst_key_dir", 32'(key_dir), 0);
    check("rst_key_round", 32'(key_round), 0);
    check("rst_invmixcol", 32'(en_invmixcol), 0);
    check("rst_out_en", 32'(out_en), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    in_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    kill_n = 1'b1;
    base = cyc;
  endtask

  task automatic drain(input int c);
    at(c);
    check("left_start", exp_start_q.size(), 0);
    check("left_out_en", exp_out_q.size(), 0);
    check("left_irq", exp_irq_q.size(), 0);
    check("left_key_step", exp_step_q.size(), 0);
    check("left_invmixcol", exp_imc_q.size(), 0);
  endtask

  // Scoreboard monitor: compare each DUT event against the expected queue.
  always @(negedge clk) begin
    if (start) begin
      if (exp_start_q.size() == 0) unexpected("start");
      else check("start_cycle", 32'(cyc), exp_start_q.pop_front());
    end
    if (out_en) begin
      if (exp_out_q.size() == 0) unexpected("out_en");
      else check("out_en_cycle", 32'(cyc), exp_out_q.pop_front());
    end
    if (irq) begin
      if (exp_irq_q.size() == 0) unexpected("collision_irq");
      else check("irq_cycle", 32'(cyc), exp_irq_q.pop_front());
    end
    if (key_step) begin
      if (exp_step_q.size() == 0) unexpected("key_step");
      else begin
        step_t s;
        s = exp_step_q.pop_front();
        check("key_step_cycle", 32'(cyc), s.c);
        check("key_dir", 32'(key_dir), 32'(s.dir));
        check("key_round", 32'(key_round), 32'(s.rnd));
      end
    end
    if (en_invmixcol) begin
      if (exp_imc_q.size() == 0) unexpected("en_invmixcol");
      else begin
        step_t s;
        s = exp_imc_q.pop_front();
        check("invmixcol_cycle", 32'(cyc), s.c);
        check("invmixcol_round", 32'(key_round), 32'(s.rnd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single block from IDLE, request at cycle 5.
    do_reset();
    expect_block(5, 1000);
    busy_at(4, 1'b0);
    pulse_in(5);
    busy_at(6, 1'b1);
    busy_at(45, 1'b1);
    busy_at(46, 1'b0);
    drain(50);

    // Back-to-back: second request lands in the DONE cycle.
    do_reset();
    expect_block(5, 1000);
    expect_block(46, 1000);
    pulse_in(5);
    pulse_in(46);
    drain(92);

    // Requests while busy are dropped and pulse the collision flag.
    do_reset();
    expect_block(5, 1000);
    expect_irq(21);
    expect_irq(22);
    pulse_in(5);
    at(20);
    in_en = 1'b1;
    at(22);
    in_en = 1'b0;
    drain(50);

    // Reset mid-block abandons it; a later request runs from scratch.
    do_reset();
    expect_block(5, 30);
    pulse_in(5);
    at(30);
    kill_n = 1'b0;
    in_en  = 1'b1;
    @(negedge clk);
    check("midrst_start", 32'(start), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_key_step", 32'(key_step), 0);
    check("midrst_key_round", 32'(key_round), 0);
    check("midrst_out_en", 32'(out_en), 0);
    at(32);
    in_en  = 1'b0;
    kill_n = 1'b1;
    expect_block(40, 1000);
    pulse_in(40);
    drain(85);

    // Request held high: blocks every 41 cycles, a pulse per busy cycle.
    do_reset();
    expect_block(0, 1000);
    expect_block(41, 1000);
    expect_block(82, 1000);
    for (int c = 2; c <= 41; c++) expect_irq(c);
    for (int c = 43; c <= 82; c++) expect_irq(c);
    in_en = 1'b1;
    at(83);
    in_en = 1'b0;
    drain(128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
